// File: rtl/prog_ctr_if.sv
// Control-stage to program-counter bus: Start/branch controls in, fetch address out.
// Stall exists only when PROGCTR_STALL_EN is defined.
interface prog_ctr_if #(
    parameter int PC_W = 10
);
    logic            Start;
    logic            BranchAbsEn;
    logic            BranchRelEn;
    logic            ALU_flag;
`ifdef PROGCTR_STALL_EN
    logic            Stall;
`endif
    logic [PC_W-1:0] Target;
    logic [PC_W-1:0] ProgCtr;
    logic [1:0]      dbg_state;

    // Control stage drives the requests; the PC block answers with a registered address.
    modport master (
        output Start, BranchAbsEn, BranchRelEn, ALU_flag,
`ifdef PROGCTR_STALL_EN
        output Stall,
`endif
        output Target,
        input  ProgCtr, dbg_state
    );

    modport slave (
        input  Start, BranchAbsEn, BranchRelEn, ALU_flag,
`ifdef PROGCTR_STALL_EN
        input  Stall,
`endif
        input  Target,
        output ProgCtr, dbg_state
    );
endinterface

// File: rtl/prog_ctr.sv
// Instruction-fetch program counter with multi-program Start selection and branches.
// Optional PROGCTR_STALL_EN adds a Stall input that freezes the PC while running.
module prog_ctr #(
    parameter int PC_W       = 10,
    parameter int NUM_PROGS  = 3,
    parameter int PROG0_ADDR = 0,
    parameter int PROG1_ADDR = 256,
    parameter int PROG2_ADDR = 512,
    parameter int PROG3_ADDR = 768
) (
    input logic        Clk,
    input logic        Reset,
    prog_ctr_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [1:0]      r_sel;
    logic            r_started;
    logic            r_start_q;

    logic            w_start_rise;
    logic [1:0]      w_sel_next;
    logic            w_stall;

    function automatic logic [PC_W-1:0] entry_addr(input logic [1:0] sel);
        case (sel)
            2'd0:    entry_addr = PC_W'(PROG0_ADDR);
            2'd1:    entry_addr = PC_W'(PROG1_ADDR);
            2'd2:    entry_addr = PC_W'(PROG2_ADDR);
            default: entry_addr = PC_W'(PROG3_ADDR);
        endcase
    endfunction

    assign w_start_rise = bus.Start && !r_start_q;
    // The first Start after reset always picks program 0; later ones rotate.
    assign w_sel_next   = !r_started                  ? 2'd0 :
                          (r_sel == 2'(NUM_PROGS - 1)) ? 2'd0 : r_sel + 2'd1;

`ifdef PROGCTR_STALL_EN
    assign w_stall = bus.Stall;
`else
    assign w_stall = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_pc      <= '0;
            r_sel     <= 2'd0;
            r_started <= 1'b0;
            r_start_q <= 1'b0;
        end else begin
            r_start_q <= bus.Start;
            if (w_start_rise) begin
                r_sel     <= w_sel_next;
                r_started <= 1'b1;
                r_pc      <= entry_addr(w_sel_next);
                r_state   <= LOAD;
            end else begin
                case (r_state)
                    IDLE: if (bus.Start) r_state <= LOAD;
                    LOAD: begin
                        // The falling edge only changes state; the PC starts moving one edge later.
                        if (!bus.Start) r_state <= RUN;
                        else            r_pc    <= entry_addr(r_sel);
                    end
                    RUN: begin
                        if (w_stall)                            r_pc <= r_pc;
                        else if (bus.BranchAbsEn)               r_pc <= bus.Target;
                        else if (bus.BranchRelEn && bus.ALU_flag) r_pc <= r_pc + bus.Target;
                        else                                    r_pc <= r_pc + 1'b1;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ProgCtr   = r_pc;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_prog_ctr.sv
// Bench for prog_ctr: directed sequence with literal expectations, then random traffic,
// every cycle compared against an arithmetic model of the PC rules.
module tb_prog_ctr;
    localparam int PC_W      = 10;
    localparam int NUM_PROGS = 3;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    prog_ctr_if #(.PC_W(PC_W)) bus ();

    prog_ctr #(.PC_W(PC_W), .NUM_PROGS(NUM_PROGS)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 = waiting for first Start, 1 = parked at entry, 2 = running.
    int entry_tbl [4] = '{0, 256, 512, 768};
    int m_pc, m_sel, m_phase;
    bit m_started, m_prev, m_valid;
    int offs;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 0; m_sel = 0; m_phase = 0;
            m_started = 0; m_prev = 0; m_valid = 1;
        end else if (m_valid) begin
            if (bus.Start && !m_prev) begin
                m_sel     = m_started ? (m_sel + 1) % NUM_PROGS : 0;
                m_started = 1;
                m_pc      = entry_tbl[m_sel];
                m_phase   = 1;
            end else if (m_phase == 0) begin
                if (bus.Start) m_phase = 1;
            end else if (m_phase == 1) begin
                if (!bus.Start) m_phase = 2;
            end else begin
`ifdef PROGCTR_STALL_EN
                if (bus.Stall) begin
                end else
`endif
                if (bus.BranchAbsEn) m_pc = int'(bus.Target);
                else if (bus.BranchRelEn && bus.ALU_flag) begin
                    offs = int'(bus.Target);
                    if (offs >= 512) offs = offs - 1024;
                    m_pc = ((m_pc + offs) % 1024 + 1024) % 1024;
                end else m_pc = (m_pc + 1) % 1024;
            end
            m_prev = bus.Start;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (bus.ProgCtr !== PC_W'(m_pc)) begin
                failures++;
                $display("FAIL model_pc t=%0t actual=%0d expected=%0d", $time, bus.ProgCtr, m_pc);
            end
        end
    end

    task automatic cyc(input bit r, input bit s, input bit abs_en, input bit rel_en,
                       input bit flag, input int tgt, input bit stall = 1'b0);
        rst             = r;
        bus.Start       = s;
        bus.BranchAbsEn = abs_en;
        bus.BranchRelEn = rel_en;
        bus.ALU_flag    = flag;
        bus.Target      = PC_W'(tgt);
`ifdef PROGCTR_STALL_EN
        bus.Stall       = stall;
`else
        if (stall) $display("note: stall request ignored in this build");
`endif
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int exp);
        checks++;
        if (bus.ProgCtr !== PC_W'(exp)) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, bus.ProgCtr, exp);
        end
    endtask

    initial begin
        bit s_lvl;
        rst = 1'b1; bus.Start = 0; bus.BranchAbsEn = 0; bus.BranchRelEn = 0;
        bus.ALU_flag = 0; bus.Target = '0;
`ifdef PROGCTR_STALL_EN
        bus.Stall = 0;
`endif
        cyc(1, 0, 0, 0, 0, 0);       chk("reset", 0);
        cyc(0, 0, 0, 0, 0, 0);       chk("idle_hold", 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 1, 1, 10);  chk("load_ignores_branch", 0);
        end
        cyc(0, 0, 0, 0, 0, 0);       chk("load_to_run", 0);
        cyc(0, 0, 0, 0, 0, 0);       chk("run_step1", 1);
        cyc(0, 0, 0, 0, 0, 0);       chk("run_step2", 2);
        cyc(0, 0, 1, 0, 0, 10);      chk("abs_10", 10);
        cyc(0, 0, 0, 1, 0, 5);       chk("rel_not_taken", 11);
        cyc(0, 0, 0, 1, 1, 5);       chk("rel_taken", 16);
        cyc(0, 0, 1, 1, 1, 20);      chk("abs_wins", 20);
        cyc(0, 0, 1, 0, 0, 16);      chk("abs_16", 16);
        cyc(0, 0, 0, 1, 1, 'h3FC);   chk("rel_backward", 12);
        cyc(0, 0, 1, 0, 0, 1023);    chk("abs_1023", 1023);
        cyc(0, 0, 0, 0, 0, 0);       chk("wrap_to_0", 0);
        cyc(0, 0, 0, 0, 1, 7);       chk("flag_alone", 1);
`ifdef PROGCTR_STALL_EN
        cyc(0, 0, 1, 0, 0, 5);       chk("abs_5", 5);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 0, 40, 1); chk("stall_hold", 5);
        end
        cyc(0, 0, 1, 0, 0, 40, 0);   chk("stall_release", 40);
`endif
        cyc(0, 1, 0, 0, 0, 0);       chk("start2_prog1", 256);
        cyc(0, 0, 0, 0, 0, 0);       chk("prog1_run_entry", 256);
        cyc(0, 1, 0, 0, 0, 0);       chk("start3_prog2", 512);
        cyc(0, 0, 0, 0, 0, 0);       chk("prog2_run_entry", 512);
        cyc(0, 1, 0, 0, 0, 0);       chk("start4_wrap_prog0", 0);
        cyc(0, 0, 0, 0, 0, 0);       chk("prog0_run_entry", 0);
        cyc(0, 1, 0, 0, 0, 0);       chk("start5_prog1", 256);
        cyc(0, 0, 0, 0, 0, 0);       chk("prog1_again", 256);
        cyc(0, 0, 1, 0, 0, 300);     chk("abs_300", 300);
        cyc(1, 0, 0, 0, 0, 0);       chk("reset_mid_run", 0);
        cyc(0, 1, 0, 0, 0, 0);       chk("start_after_reset_prog0", 0);
        cyc(0, 0, 0, 0, 0, 0);       chk("after_reset_run_entry", 0);
        cyc(0, 0, 0, 0, 0, 0);       chk("after_reset_step", 1);

        s_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) s_lvl = ~s_lvl;
            cyc($urandom_range(0, 249) == 0, s_lvl,
                $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                $urandom_range(0, 5) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
